// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode instruction buffer.
//   NOP_INSTR   : instruction presented to decode when the buffer is empty
//   HALT_OPCODE : opcode field [15:11] that identifies a HALT instruction
//   EMPTY_PC    : PC / PC+2 value presented when the buffer is empty
//   entry_t     : one queued fetch record {instr, pc, inc_pc}
package fetch_decode_pkg;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;
  localparam logic [15:0] EMPTY_PC    = 16'h0000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] inc_pc;
  } entry_t;

endpackage

// File: rtl/fdb_entry_mem.sv
// Register-array storage for the fetch/decode buffer.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write slot
//   wdata  in   packed entry to store
//   raddr  in   read slot (asynchronous read)
//   rdata  out  packed entry at raddr
module fdb_entry_mem #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: data storage has no reset; the top gates outputs whenever the
  // buffer is empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Instruction queue between fetch and decode. Each accepted fetch stores
// {instr, pc, pc+2}; decode stalls back-pressure fetch only through in_ready.
// A resolved branch/jump (flush) discards every queued wrong-path entry.
// Optional HALT detection is enabled with macro IFID_HALT_DETECT_EN: once a
// HALT is accepted, intake freezes until flush or reset.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready                  fetch handshake
//   in_instr, in_pc, in_inc_pc         fetched record
//   flush                              discard all entries
//   out_valid/out_ready                decode handshake
//   out_instr, out_pc, out_inc_pc      head record (NOP/0/0 when empty)
//   count                              occupied entries
//   halted                             HALT captured, intake frozen
//   err                                sticky pointer/count inconsistency
module fetch_decode_buffer
  import fetch_decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_instr,
  input  logic [DW-1:0]          in_pc,
  input  logic [DW-1:0]          in_inc_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_instr,
  output logic [DW-1:0]          out_pc,
  output logic [DW-1:0]          out_inc_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   halted,
  output logic                   err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, ptr_diff;
  logic [CW-1:0] count_next;
  logic          enq, deq, mismatch;
  entry_t        wr_entry, head;

  // Handshakes depend only on registered state; no out_ready -> in_ready path.
  assign out_valid = (count != '0);
  assign in_ready  = (count != CW'(DEPTH)) & ~halted;
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  assign wr_entry = '{instr: in_instr, pc: in_pc, inc_pc: in_inc_pc};

  fdb_entry_mem #(
    .DEPTH (DEPTH),
    .WIDTH (3 * DW),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (enq & ~flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign out_instr  = out_valid ? head.instr  : NOP_INSTR;
  assign out_pc     = out_valid ? head.pc     : EMPTY_PC;
  assign out_inc_pc = out_valid ? head.inc_pc : EMPTY_PC;

  always_comb begin
    // NOTE: default assignment first so no path leaves count_next unassigned
    // (otherwise a latch would be inferred).
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  // Pointer distance wraps mod DEPTH, so a full buffer shows distance 0,
  // matching the low bits of count == DEPTH.
  assign ptr_diff = wr_ptr - rd_ptr;
  assign mismatch = (ptr_diff != count[PW-1:0]) || (count > CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err | mismatch;
  end

`ifdef IFID_HALT_DETECT_EN
  // A HALT may be wrong-path, so flush releases the freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         halted <= 1'b0;
    else if (flush)                                     halted <= 1'b0;
    else if (enq && (in_instr[15:11] == HALT_OPCODE))   halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

endmodule
